mod_addsub_pipe: RTL and testbench

MOD_ADDSUB_PIPE -- requirements
Module: mod_addsub_pipe

---
 rtl/mod_addsub_pipe.sv | 150 +++++++++++++++
 tb/tb_mod_addsub_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
`timescale 1ns/1ps
// mod_addsub_pipe
// ---------------
// Multi-lane modular adder/subtractor with a two-stage valid/ready pipeline.
// Every lane of a transaction shares one modulus iQ and one mode bit iSub.
// Stage 1 holds the raw (BITWIDTH+1)-bit sum or difference, the per-lane
// range check and Q. Stage 2 holds the corrected, reduced result.
//
// Ports
//   iClk    : clock, all state on the rising edge
//   iRstN   : asynchronous active-low reset
//   iClr    : synchronous flush of both pipeline stages
//   iValid  : input transaction valid
//   oReady  : block accepts an input this cycle
//   iSub    : 0 = (a+b) mod Q, 1 = (a-b) mod Q
//   iData0  : operand a, lane k at [k*BITWIDTH +: BITWIDTH]
//   iData1  : operand b, same packing
//   iQ      : modulus shared by all lanes
//   oValid  : output transaction valid
//   iReady  : downstream accepts the output
//   oData   : per-lane result, same packing
//   oErr    : per-lane out-of-range flag
module mod_addsub_pipe #(
    parameter int BITWIDTH = 16,
    parameter int LANES    = 4
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iClr,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic                         iSub,
    input  logic [LANES*BITWIDTH-1:0]    iData0,
    input  logic [LANES*BITWIDTH-1:0]    iData1,
    input  logic [BITWIDTH-1:0]          iQ,
    output logic                         oValid,
    input  logic                         iReady,
    output logic [LANES*BITWIDTH-1:0]    oData,
    output logic [LANES-1:0]             oErr
);

    // Whole pipeline advances as a unit: it moves whenever the output
    // register is empty or its contents are being taken downstream.
    logic advance;

    // Stage 1 state
    logic                             s1Valid;
    logic                             s1Sub;
    logic [LANES-1:0][BITWIDTH:0]     s1Raw;
    logic [LANES-1:0]                 s1Err;
    logic [BITWIDTH-1:0]              s1Q;

    // Stage 1 combinational inputs
    logic [LANES-1:0][BITWIDTH:0]     rawNext;
    logic [LANES-1:0]                 errNext;

    // Stage 2 combinational correction
    logic [LANES-1:0][BITWIDTH:0]     reduceAdd;
    logic [LANES-1:0][BITWIDTH-1:0]   wrapSub;
    logic [LANES-1:0][BITWIDTH-1:0]   corrected;

    // Stage 2 state is the output register itself
    logic                             s2Valid;

    assign advance = !s2Valid || iReady;
    assign oReady  = advance;
    assign oValid  = s2Valid;

    // Raw sum/difference with one extra bit so the add carry is never lost
    // and the subtract borrow lands in the top bit. A lane is out of range
    // when either operand is not below Q; Q == 0 makes every lane fail
    // automatically because any operand is >= 0.
    always_comb begin
        rawNext = '0;
        errNext = '0;
        for (int k = 0; k < LANES; k++) begin
            if (iSub) begin
                rawNext[k] = {1'b0, iData0[k*BITWIDTH +: BITWIDTH]}
                           - {1'b0, iData1[k*BITWIDTH +: BITWIDTH]};
            end else begin
                rawNext[k] = {1'b0, iData0[k*BITWIDTH +: BITWIDTH]}
                           + {1'b0, iData1[k*BITWIDTH +: BITWIDTH]};
            end
            errNext[k] = (iData0[k*BITWIDTH +: BITWIDTH] >= iQ)
                      || (iData1[k*BITWIDTH +: BITWIDTH] >= iQ);
        end
    end

    // Stage 1 register. Flush beats a transfer; payload is only captured
    // for real transactions so bubbles leave the data untouched.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            s1Valid <= 1'b0;
            s1Sub   <= 1'b0;
            s1Raw   <= '0;
            s1Err   <= '0;
            s1Q     <= '0;
        end else if (iClr) begin
            s1Valid <= 1'b0;
        end else if (advance) begin
            s1Valid <= iValid;
            if (iValid) begin
                s1Sub <= iSub;
                s1Raw <= rawNext;
                s1Err <= errNext;
                s1Q   <= iQ;
            end
        end
    end

    // Correction: an in-range add is below 2Q, so one conditional subtract
    // of Q suffices. For subtract, a set top bit means a < b and the low
    // bits hold a-b modulo 2^BITWIDTH, so adding Q wraps to the answer.
    always_comb begin
        reduceAdd = '0;
        wrapSub   = '0;
        corrected = '0;
        for (int k = 0; k < LANES; k++) begin
            reduceAdd[k] = s1Raw[k] - {1'b0, s1Q};
            wrapSub[k]   = s1Raw[k][BITWIDTH-1:0] + s1Q;
            if (s1Err[k]) begin
                corrected[k] = '0;
            end else if (s1Sub) begin
                corrected[k] = s1Raw[k][BITWIDTH] ? wrapSub[k]
                                                  : s1Raw[k][BITWIDTH-1:0];
            end else begin
                corrected[k] = (s1Raw[k] >= {1'b0, s1Q}) ? reduceAdd[k][BITWIDTH-1:0]
                                                         : s1Raw[k][BITWIDTH-1:0];
            end
        end
    end

    // Stage 2 / output register. Holds steady while stalled.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            s2Valid <= 1'b0;
            oData   <= '0;
            oErr    <= '0;
        end else if (iClr) begin
            s2Valid <= 1'b0;
        end else if (advance) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                oData <= corrected;
                oErr  <= s1Err;
            end
        end
    end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
`timescale 1ns/1ps
// tb_mod_addsub_pipe
// ------------------
// Self-checking bench for mod_addsub_pipe with BITWIDTH=16, LANES=4.
// Directed scenarios cover the reference vectors, stalls, lane errors,
// flush and asynchronous reset; a randomized run compares against a
// plain-arithmetic model through an expected-result queue.
module tb_mod_addsub_pipe;

    localparam int W = 16;
    localparam int L = 4;

    logic           iClk = 1'b0;
    logic           iRstN;
    logic           iClr;
    logic           iValid;
    logic           oReady;
    logic           iSub;
    logic [L*W-1:0] iData0;
    logic [L*W-1:0] iData1;
    logic [W-1:0]   iQ;
    logic           oValid;
    logic           iReady;
    logic [L*W-1:0] oData;
    logic [L-1:0]   oErr;

    int checkCount = 0;
    int failCount  = 0;

    mod_addsub_pipe #(.BITWIDTH(W), .LANES(L)) dut (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iClr   (iClr),
        .iValid (iValid),
        .oReady (oReady),
        .iSub   (iSub),
        .iData0 (iData0),
        .iData1 (iData1),
        .iQ     (iQ),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
        .oErr   (oErr)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 iClk = ~iClk;

    // Reference for one lane: {err, result} from the modular rules.
    function automatic logic [W:0] modelLane(input logic sub, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] q);
        longint la, lb, lq, r;
        la = a; lb = b; lq = q;
        if (lq == 0 || la >= lq || lb >= lq) return {1'b1, {W{1'b0}}};
        if (sub) r = (la - lb + lq) % lq;
        else     r = (la + lb) % lq;
        return {1'b0, W'(r)};
    endfunction

    // Present the same operands on every lane.
    task automatic drive(input logic v, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] q);
        iValid = v;
        iSub   = s;
        iData0 = {L{a}};
        iData1 = {L{b}};
        iQ     = q;
    endtask

    task automatic nextCycle();
        @(posedge iClk);
        #1;
    endtask

    // Reset values must appear before any clock edge.
    task automatic test_reset();
        iRstN = 1'b1;
        iClr = 1'b0;
        iReady = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        #1 iRstN = 1'b0;
        #2;
        checkCount++;
        if (oValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_oValid: got %b, expected 0", oValid); end
        checkCount++;
        if (oData !== '0) begin failCount++; $display("[TB] FAIL reset_oData: got %h, expected 0", oData); end
        checkCount++;
        if (oErr !== '0) begin failCount++; $display("[TB] FAIL reset_oErr: got %b, expected 0", oErr); end
        checkCount++;
        if (oReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_oReady: got %b, expected 1", oReady); end
        @(posedge iClk);
        @(posedge iClk);
        #1 iRstN = 1'b1;
        @(negedge iClk);
        checkCount++;
        if (oReady !== 1'b1 || oValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL post_reset: oReady=%b oValid=%b, expected 1/0", oReady, oValid);
        end
        nextCycle();
    endtask

    // Add a=10,b=20 with Q stepping 23..32, one per cycle, latency 2.
    task automatic test_add_sweep();
        int expv[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 30, 30};
        logic [W-1:0] e;
        for (int i = 0; i < 13; i++) begin
            if (i < 10) drive(1'b1, 1'b0, 16'd10, 16'd20, W'(23 + i));
            else        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            @(negedge iClk);
            checkCount++;
            if (i < 2 || i > 11) begin
                if (oValid !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL sweep_bubble[%0d]: oValid=%b, expected 0", i, oValid);
                end
            end else begin
                e = W'(expv[i-2]);
                if (oValid !== 1'b1 || oData !== {L{e}} || oErr !== '0) begin
                    failCount++;
                    $display("[TB] FAIL sweep[%0d]: oValid=%b oData=%h oErr=%b, expected 1 %h 0",
                             i - 2, oValid, oData, oErr, {L{e}});
                end
            end
            nextCycle();
        end
    endtask

    // Subtract both ways and the carry corner at the top of the range.
    task automatic test_sub_edge();
        logic          sv[3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0]  av[3] = '{16'd10, 16'd20, 16'd65534};
        logic [W-1:0]  bv[3] = '{16'd20, 16'd10, 16'd65534};
        logic [W-1:0]  qv[3] = '{16'd23, 16'd23, 16'd65535};
        logic [W-1:0]  ev[3] = '{16'd13, 16'd10, 16'd65533};
        for (int i = 0; i < 5; i++) begin
            if (i < 3) drive(1'b1, sv[i], av[i], bv[i], qv[i]);
            else       drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            @(negedge iClk);
            if (i >= 2) begin
                checkCount++;
                if (oValid !== 1'b1 || oData !== {L{ev[i-2]}}) begin
                    failCount++;
                    $display("[TB] FAIL sub_edge[%0d]: oValid=%b oData=%h, expected 1 %h",
                             i - 2, oValid, oData, {L{ev[i-2]}});
                end
            end
            nextCycle();
        end
        nextCycle();
    endtask

    // Four transfers, downstream stalls three cycles after the first result.
    task automatic test_stall();
        int idx = 0;
        int outIdx = 0;
        int stallCnt = 0;
        logic wasStalled = 1'b0;
        logic [L*W-1:0] held = '0;
        logic [W-1:0] e;
        for (int cyc = 0; cyc < 20; cyc++) begin
            iReady = !(cyc >= 3 && cyc <= 5);
            if (idx < 4) drive(1'b1, 1'b0, 16'd10, 16'd20, W'(23 + idx));
            else         drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            @(negedge iClk);
            checkCount++;
            if (oReady !== !(oValid && !iReady)) begin
                failCount++;
                $display("[TB] FAIL stall_oReady[%0d]: got %b, expected %b", cyc, oReady, !(oValid && !iReady));
            end
            if (wasStalled) begin
                checkCount++;
                if (oValid !== 1'b1 || oData !== held) begin
                    failCount++;
                    $display("[TB] FAIL stall_hold[%0d]: oValid=%b oData=%h, expected 1 %h", cyc, oValid, oData, held);
                end
            end
            if (oValid && !iReady) stallCnt++;
            if (oValid && iReady) begin
                checkCount++;
                e = W'(7 - outIdx);
                if (outIdx >= 4 || oData !== {L{e}}) begin
                    failCount++;
                    $display("[TB] FAIL stall_order[%0d]: oData=%h, expected %h", outIdx, oData, {L{e}});
                end
                outIdx++;
            end
            wasStalled = oValid && !iReady;
            held = oData;
            if (iValid && oReady) idx++;
            nextCycle();
        end
        iReady = 1'b1;
        checkCount++;
        if (outIdx !== 4 || idx !== 4) begin
            failCount++;
            $display("[TB] FAIL stall_count: delivered %0d accepted %0d, expected 4 4", outIdx, idx);
        end
        checkCount++;
        if (stallCnt !== 3) begin
            failCount++;
            $display("[TB] FAIL stall_cycles: got %0d, expected 3", stallCnt);
        end
    endtask

    // Lane 2 out of range with the other lanes valid, then Q = 0.
    task automatic test_err();
        logic [L*W-1:0] expD[2];
        logic [L-1:0]   expE[2];
        expD[0] = {16'd10, 16'd0, 16'd12, 16'd4};
        expE[0] = 4'b0100;
        expD[1] = '0;
        expE[1] = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            iValid = (i < 2);
            iSub   = 1'b0;
            iData0 = {16'd3, 16'd23, 16'd4, 16'd5};
            iData1 = {16'd7, 16'd1, 16'd8, 16'd22};
            iQ     = (i == 0) ? 16'd23 : 16'd0;
            @(negedge iClk);
            if (i >= 2) begin
                checkCount++;
                if (oValid !== 1'b1 || oData !== expD[i-2] || oErr !== expE[i-2]) begin
                    failCount++;
                    $display("[TB] FAIL lane_err[%0d]: oValid=%b oData=%h oErr=%b, expected 1 %h %b",
                             i - 2, oValid, oData, oErr, expD[i-2], expE[i-2]);
                end
            end
            nextCycle();
        end
    endtask

    // Flush with two transactions in flight, flush on an idle input, then resume.
    task automatic test_clr();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd23);
        nextCycle();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd24);
        nextCycle();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd25);
        iReady = 1'b0;
        iClr = 1'b1;
        @(negedge iClk);
        checkCount++;
        if (oValid !== 1'b1 || oData !== {L{16'd7}}) begin
            failCount++;
            $display("[TB] FAIL clr_pre: oValid=%b oData=%h, expected 1 %h", oValid, oData, {L{16'd7}});
        end
        nextCycle();
        iClr = 1'b0;
        iReady = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            checkCount++;
            if (oValid !== 1'b0 || oReady !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL clr_flushed[%0d]: oValid=%b oReady=%b, expected 0 1", i, oValid, oReady);
            end
            nextCycle();
        end
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd30);
        iClr = 1'b1;
        nextCycle();
        iClr = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checkCount++;
            if (oValid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL clr_drop[%0d]: oValid=%b, expected 0", i, oValid);
            end
            nextCycle();
        end
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd31);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checkCount++;
            if (oValid !== (i == 2) || (i == 2 && oData !== {L{16'd30}})) begin
                failCount++;
                $display("[TB] FAIL clr_resume[%0d]: oValid=%b oData=%h, expected %b %h",
                         i, oValid, oData, (i == 2), {L{16'd30}});
            end
            nextCycle();
            drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        end
    endtask

    // Reset pulsed between edges mid-stream; nothing stale may come out.
    task automatic test_async_reset();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd23);
        nextCycle();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd24);
        nextCycle();
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd25);
        @(negedge iClk);
        checkCount++;
        if (oValid !== 1'b1 || oData !== {L{16'd7}}) begin
            failCount++;
            $display("[TB] FAIL arst_pre: oValid=%b oData=%h, expected 1 %h", oValid, oData, {L{16'd7}});
        end
        #2 iRstN = 1'b0;
        #1;
        checkCount++;
        if (oValid !== 1'b0 || oData !== '0 || oErr !== '0 || oReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL arst_now: oValid=%b oData=%h oErr=%b oReady=%b, expected 0 0 0 1",
                     oValid, oData, oErr, oReady);
        end
        nextCycle();
        drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        nextCycle();
        iRstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge iClk);
            checkCount++;
            if (oValid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL arst_stale[%0d]: oValid=%b oData=%h, expected 0", i, oValid, oData);
            end
            nextCycle();
        end
        drive(1'b1, 1'b0, 16'd10, 16'd20, 16'd26);
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            checkCount++;
            if (oValid !== (i == 2) || (i == 2 && oData !== {L{16'd4}})) begin
                failCount++;
                $display("[TB] FAIL arst_resume[%0d]: oValid=%b oData=%h, expected %b %h",
                         i, oValid, oData, (i == 2), {L{16'd4}});
            end
            nextCycle();
            drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
        end
    endtask

    // Random traffic with random back-pressure against the lane model.
    task automatic test_random();
        logic [L*W-1:0] qData[$];
        logic [L-1:0]   qErr[$];
        logic [L*W-1:0] ed, held, gotD;
        logic [L-1:0]   ee, gotE;
        logic [W-1:0]   a, b, q;
        logic [W:0]     r;
        logic           wasStalled = 1'b0;
        int             sel;
        held = '0;
        for (int cyc = 0; cyc < 460; cyc++) begin
            if (cyc < 400) begin
                iReady = ($urandom % 4) != 0;
                iValid = ($urandom % 3) != 0;
                iSub   = 1'($urandom % 2);
                sel = $urandom % 8;
                if (sel == 0)      q = 16'd0;
                else if (sel == 1) q = 16'hFFFF;
                else if (sel == 2) q = W'($urandom_range(1, 40));
                else               q = W'($urandom_range(1, 65535));
                iQ = q;
                for (int k = 0; k < L; k++) begin
                    if ($urandom % 8 == 0 || q == 0) a = W'($urandom);
                    else                             a = W'($urandom % q);
                    if ($urandom % 8 == 0 || q == 0) b = W'($urandom);
                    else                             b = W'($urandom % q);
                    iData0[k*W +: W] = a;
                    iData1[k*W +: W] = b;
                    r = modelLane(iSub, a, b, q);
                    ed[k*W +: W] = r[W-1:0];
                    ee[k] = r[W];
                end
            end else begin
                iReady = 1'b1;
                drive(1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
            end
            @(negedge iClk);
            if (wasStalled) begin
                checkCount++;
                if (oValid !== 1'b1 || oData !== held) begin
                    failCount++;
                    $display("[TB] FAIL rand_hold[%0d]: oValid=%b oData=%h, expected 1 %h", cyc, oValid, oData, held);
                end
            end
            if (oValid && iReady) begin
                checkCount++;
                if (qData.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL rand_extra[%0d]: unexpected output %h", cyc, oData);
                end else begin
                    gotD = qData.pop_front();
                    gotE = qErr.pop_front();
                    if (oData !== gotD || oErr !== gotE) begin
                        failCount++;
                        $display("[TB] FAIL rand_data[%0d]: oData=%h oErr=%b, expected %h %b",
                                 cyc, oData, oErr, gotD, gotE);
                    end
                end
            end
            wasStalled = oValid && !iReady;
            held = oData;
            if (iValid && oReady) begin
                qData.push_back(ed);
                qErr.push_back(ee);
            end
            nextCycle();
        end
        checkCount++;
        if (qData.size() != 0) begin
            failCount++;
            $display("[TB] FAIL rand_drain: %0d results never delivered, expected 0", qData.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_sweep();
        test_sub_edge();
        test_stall();
        test_err();
        test_clr();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
